jpeg_enc_quant_zz: RTL

Quantisation and zigzag-reorder stage placed directly downstream of the DCT. It reads one 64-entry DCT data unit from the DCTDU RAM and scales each coefficient by the Y or UV entry of the fdtbl ROM. Each result is rounded and saturated, then written to the ZIGZAG DU RAM at the position given by the zigzag index ROM. It also reports the last non-zero AC position for the Huffman stage.

---
 rtl/jpeg_enc_pkg.sv | 10 +
 rtl/jpeg_enc_quant_round.sv | 28 ++
 rtl/jpeg_enc_quant_zz.sv | 114 +++++++++++
 3 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared constants and types for the JPEG encoder datapath stages.
package jpeg_enc_pkg;
    localparam int DU_SIZE       = 64;
    localparam int DCT_W         = 18;
    localparam int ZZ_W          = 15;
    localparam int FDTBL_FRAC    = 8;
    localparam int FDTBL_UV_BASE = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/jpeg_enc_quant_round.sv
// Round-to-nearest (halves away from zero) of a fixed-point product, saturated to Q_W bits.
module jpeg_enc_quant_round #(
    parameter int P_W  = 27,
    parameter int Q_W  = 15,
    parameter int FRAC = 8
) (
    input  logic signed [P_W-1:0] p,
    output logic signed [Q_W-1:0] q
);
    localparam logic [P_W:0] HALF    = (P_W+1)'(1) << (FRAC - 1);
    localparam logic [P_W:0] POS_LIM = (P_W+1)'((1 << (Q_W - 1)) - 1);
    localparam logic [P_W:0] NEG_LIM = (P_W+1)'(1 << (Q_W - 1));

    logic           neg;
    logic [P_W:0]   mag;
    logic [P_W:0]   rnd;

    // One extra bit so |most-negative product| stays representable.
    always_comb begin
        neg = p[P_W-1];
        mag = neg ? -{p[P_W-1], p} : {1'b0, p};
        rnd = (mag + HALF) >> FRAC;
        if (!neg)
            q = (rnd > POS_LIM) ? {1'b0, {(Q_W-1){1'b1}}} : $signed(rnd[Q_W-1:0]);
        else
            q = (rnd >= NEG_LIM) ? {1'b1, {(Q_W-1){1'b0}}} : -$signed(rnd[Q_W-1:0]);
    end
endmodule

// File: rtl/jpeg_enc_quant_zz.sv
// Quantise one 64-coefficient DCT data unit and write it in zigzag order; reports last non-zero AC.
module jpeg_enc_quant_zz
    import jpeg_enc_pkg::*;
#(
    parameter int IN_W      = DCT_W,
    parameter int OUT_W     = ZZ_W,
    parameter int FRAC_BITS = FDTBL_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             comp_uv,
    output logic             busy,
    output logic             done,
    output logic [5:0]       last_nz,
    output logic [5:0]       dctdu_ram_ar,
    input  logic [IN_W-1:0]  dctdu_ram_do,
    output logic [6:0]       fdtbl_rom_a,
    input  logic [7:0]       fdtbl_rom_d,
    output logic [5:0]       zzidx_rom_a,
    input  logic [5:0]       zzidx_rom_d,
    output logic [5:0]       zzdu_ram_aw,
    output logic [OUT_W-1:0] zzdu_ram_di,
    output logic             zzdu_ram_we
);
    localparam int         P_W      = IN_W + 9;
    localparam logic [5:0] IDX_LAST = 6'(DU_SIZE - 1);

    state_t                  state;
    logic [5:0]              idx;
    logic                    uv;
    logic [3:1]              vld_pipe;
    logic [2:1]              last_pipe;
    logic signed [P_W-1:0]   p_s2;
    logic [5:0]              zz_s2;
    logic [5:0]              acc;
    logic [5:0]              acc_next;
    logic                    issue;
    logic signed [P_W-1:0]   dct_x;
    logic signed [P_W-1:0]   fd_x;
    logic signed [OUT_W-1:0] q;

    assign issue        = (state == RUN);
    assign dctdu_ram_ar = idx;
    assign zzidx_rom_a  = idx;
    assign fdtbl_rom_a  = {uv, idx};
    assign zzdu_ram_we  = vld_pipe[3];

    assign dct_x = {{(P_W-IN_W){dctdu_ram_do[IN_W-1]}}, dctdu_ram_do};
    assign fd_x  = {{(P_W-8){1'b0}}, fdtbl_rom_d};

    jpeg_enc_quant_round #(.P_W(P_W), .Q_W(OUT_W), .FRAC(FRAC_BITS)) u_round (
        .p (p_s2),
        .q (q)
    );

    // Includes the coefficient being written this cycle so last_nz sees the final write.
    always_comb begin
        acc_next = acc;
        if (zz_s2 != 6'd0 && q != '0 && zz_s2 > acc)
            acc_next = zz_s2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            uv          <= 1'b0;
            vld_pipe    <= '0;
            last_pipe   <= '0;
            p_s2        <= '0;
            zz_s2       <= '0;
            zzdu_ram_aw <= '0;
            zzdu_ram_di <= '0;
            acc         <= '0;
            last_nz     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[2:1], issue};
            last_pipe <= {last_pipe[1], issue && idx == IDX_LAST};
            if (vld_pipe[1]) begin
                p_s2  <= dct_x * fd_x;
                zz_s2 <= zzidx_rom_d;
            end
            if (vld_pipe[2]) begin
                zzdu_ram_aw <= zz_s2;
                zzdu_ram_di <= q;
                acc         <= acc_next;
            end
            done <= last_pipe[2];
            if (last_pipe[2])
                last_nz <= acc_next;
            if (done)
                busy <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    uv    <= comp_uv;
                    idx   <= '0;
                    acc   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    idx <= idx + 6'd1;
                    if (idx == IDX_LAST)
                        state <= DRAIN;
                end
                DRAIN: if (last_pipe[2]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
